bcd_display_scanner: RTL and testbench



---
 rtl/bcd_display_scanner_if.sv | 30 +++
 rtl/bcd_display_scanner.sv | 122 ++++++++++++
 tb/tb_bcd_display_scanner.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// Digit/segment bundle between the BCD counter bank and the display scanner.
// The master side supplies digits and controls; the slave side drives the display.
interface bcd_display_scanner_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] digits_in;
  logic                latch;
  logic                blank_lz;
  logic [6:0]          seg_out;
  logic [DIGITS-1:0]   dig_en;
  logic                err;

  modport master (
    output digits_in,
    output latch,
    output blank_lz,
    input  seg_out,
    input  dig_en,
    input  err
  );

  modport slave (
    input  digits_in,
    input  latch,
    input  blank_lz,
    output seg_out,
    output dig_en,
    output err
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed seven-segment driver: captures BCD digits into a shadow
// register on latch and scans them one at a time with a fixed dwell per digit.
module bcd_display_scanner #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 4
) (
  input logic                    clk,
  input logic                    reset,
  bcd_display_scanner_if.slave   bus
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PreW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [6:0] SegZero  = 7'b0111111;
  localparam logic [6:0] SegDash  = 7'b1000000;
  localparam logic [6:0] SegBlank = 7'b0000000;

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [PreW-1:0]     pre_q, pre_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                err_q, err_d;

  logic                wrap;
  logic                invalid;
  logic [DIGITS-1:0]   zero_run;
  logic                all_zero;
  logic [3:0]          cur_nib;
  logic                cur_zero_run;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = SegDash;
    endcase
    return s;
  endfunction

  // Prescaler and scan index.
  always_comb begin
    wrap  = (pre_q == PreW'(REFRESH_DIV - 1));
    pre_d = wrap ? '0 : pre_q + PreW'(1);
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Capture path; err tracks the word being captured, not the shadow.
  always_comb begin
    invalid = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      invalid = invalid | (bus.digits_in[4*i +: 4] > 4'd9);
    end
    shadow_d = bus.latch ? bus.digits_in : shadow_q;
    err_d    = bus.latch ? invalid : err_q;
  end

  // zero_run[i] is set when shadow digits i..DIGITS-1 are all zero.
  always_comb begin
    all_zero = 1'b1;
    zero_run = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero    = all_zero & (shadow_q[4*i +: 4] == 4'd0);
      zero_run[i] = all_zero;
    end
  end

  always_comb begin
    cur_nib      = 4'd0;
    cur_zero_run = 1'b0;
    dig_en_d     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib      = shadow_q[4*i +: 4];
        cur_zero_run = zero_run[i];
        dig_en_d[i]  = 1'b1;
      end
    end
    // Digit 0 always shows, so a value of zero still displays "0".
    if (bus.blank_lz && (idx_q != '0) && cur_zero_run) begin
      seg_d = SegBlank;
    end else begin
      seg_d = decode(cur_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SegZero;
      dig_en_q <= DIGITS'(1);
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
      err_q    <= err_d;
    end
  end

  assign bus.seg_out = seg_q;
  assign bus.dig_en  = dig_en_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with DIGITS=4, REFRESH_DIV=4.
module tb_bcd_display_scanner;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   k;

  bcd_display_scanner_if #(.DIGITS(4)) bus ();

  bcd_display_scanner #(
    .DIGITS      (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyph per scanned digit slot, index = digit number.
  logic [6:0] exp_1234 [4] = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};
  logic [6:0] exp_9_bl [4] = '{7'b1101111, 7'b0000000, 7'b0000000, 7'b0000000};
  logic [6:0] exp_9_nb [4] = '{7'b1101111, 7'b0111111, 7'b0111111, 7'b0111111};
  logic [6:0] exp_0a05 [4] = '{7'b1101101, 7'b0111111, 7'b1000000, 7'b0000000};

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Slot visible at edge kk after reset release (kk >= 1).
  function automatic int slot_of(input int kk);
    return ((kk - 1) / 4) % 4;
  endfunction

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.latch = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    k = 0;
  endtask

  task automatic latch_word(input logic [15:0] w);
    bus.digits_in = w;
    bus.latch = 1'b1;
    tick();
    bus.latch = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    reset = 1'b1;
    bus.latch = 1'b0;
    bus.blank_lz = 1'b0;
    bus.digits_in = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.dig_en !== 4'b0001 || bus.seg_out !== 7'b0111111 || bus.err !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold c=%0d got dig_en=%b seg=%b err=%b exp 0001 0111111 0",
                 c, bus.dig_en, bus.seg_out, bus.err);
      end
    end
    reset = 1'b0;
    k = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      e = (c <= 4) ? 4'b0001 : 4'b0010;
      checks++;
      if (bus.dig_en !== e || bus.seg_out !== 7'b0111111) begin
        failures++;
        $display("FAIL reset_release k=%0d got dig_en=%b seg=%b exp %b 0111111",
                 c, bus.dig_en, bus.seg_out, e);
      end
    end
  endtask

  task automatic test_scan_1234();
    int s;
    do_reset(1);
    bus.blank_lz = 1'b0;
    latch_word(16'h1234);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL scan_1234_err got %b exp 0", bus.err);
    end
    for (int c = 0; c < 32; c++) begin
      tick();
      s = slot_of(k);
      checks++;
      if (bus.dig_en !== (4'b0001 << s) || bus.seg_out !== exp_1234[s]) begin
        failures++;
        $display("FAIL scan_1234 k=%0d got dig_en=%b seg=%b exp %b %b",
                 k, bus.dig_en, bus.seg_out, 4'b0001 << s, exp_1234[s]);
      end
    end
  endtask

  task automatic test_blank_lz();
    int s;
    do_reset(1);
    bus.blank_lz = 1'b1;
    latch_word(16'h0009);
    while (k < 24) begin
      tick();
      s = slot_of(k);
      checks++;
      if (bus.dig_en !== (4'b0001 << s) || bus.seg_out !== exp_9_bl[s]) begin
        failures++;
        $display("FAIL blank_on k=%0d got dig_en=%b seg=%b exp %b %b",
                 k, bus.dig_en, bus.seg_out, 4'b0001 << s, exp_9_bl[s]);
      end
    end
    // k=24 is the last cycle of slot 1; slot 2 shows from k=25.
    bus.blank_lz = 1'b0;
    while (k < 40) begin
      tick();
      s = slot_of(k);
      checks++;
      if (bus.dig_en !== (4'b0001 << s) || bus.seg_out !== exp_9_nb[s]) begin
        failures++;
        $display("FAIL blank_off k=%0d got dig_en=%b seg=%b exp %b %b",
                 k, bus.dig_en, bus.seg_out, 4'b0001 << s, exp_9_nb[s]);
      end
    end
  endtask

  task automatic test_invalid();
    int s;
    do_reset(1);
    bus.blank_lz = 1'b1;
    latch_word(16'h0A05);
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL invalid_err_set got %b exp 1", bus.err);
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      s = slot_of(k);
      checks++;
      if (bus.seg_out !== exp_0a05[s] || bus.err !== 1'b1) begin
        failures++;
        $display("FAIL invalid_scan k=%0d got seg=%b err=%b exp %b 1",
                 k, bus.seg_out, bus.err, exp_0a05[s]);
      end
    end
    latch_word(16'h0005);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL invalid_err_clear got %b exp 0", bus.err);
    end
  endtask

  task automatic test_ignore_unlatched();
    int s;
    do_reset(1);
    bus.blank_lz = 1'b0;
    latch_word(16'h1234);
    for (int c = 0; c < 32; c++) begin
      bus.digits_in = 16'($urandom);
      tick();
      s = slot_of(k);
      checks++;
      if (bus.dig_en !== (4'b0001 << s) || bus.seg_out !== exp_1234[s]) begin
        failures++;
        $display("FAIL ignore_unlatched k=%0d got dig_en=%b seg=%b exp %b %b",
                 k, bus.dig_en, bus.seg_out, 4'b0001 << s, exp_1234[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    bus.blank_lz = 1'b0;
    latch_word(16'h1234);
    repeat (6) tick();
    // Edge k=8 both latches 5678 and advances index 1 -> 2.
    latch_word(16'h5678);
    checks++;
    if (bus.dig_en !== 4'b0010 || bus.seg_out !== 7'b1001111) begin
      failures++;
      $display("FAIL b2b_before got dig_en=%b seg=%b exp 0010 1001111",
               bus.dig_en, bus.seg_out);
    end
    tick();
    checks++;
    if (bus.dig_en !== 4'b0100 || bus.seg_out !== 7'b1111101) begin
      failures++;
      $display("FAIL b2b_after got dig_en=%b seg=%b exp 0100 1111101",
               bus.dig_en, bus.seg_out);
    end
  endtask

  task automatic test_reset_midscan();
    do_reset(1);
    bus.blank_lz = 1'b0;
    latch_word(16'h9876);
    repeat (9) tick();
    checks++;
    if (bus.dig_en !== 4'b0100 || bus.seg_out !== 7'b1111111) begin
      failures++;
      $display("FAIL midscan_pre got dig_en=%b seg=%b exp 0100 1111111",
               bus.dig_en, bus.seg_out);
    end
    do_reset(1);
    checks++;
    if (bus.dig_en !== 4'b0001 || bus.seg_out !== 7'b0111111 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL midscan_reset got dig_en=%b seg=%b err=%b exp 0001 0111111 0",
               bus.dig_en, bus.seg_out, bus.err);
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++;
      if (bus.dig_en !== (4'b0001 << slot_of(k)) || bus.seg_out !== 7'b0111111) begin
        failures++;
        $display("FAIL midscan_zero k=%0d got dig_en=%b seg=%b exp %b 0111111",
                 k, bus.dig_en, bus.seg_out, 4'b0001 << slot_of(k));
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    k = 0;
    reset = 1'b1;
    bus.latch = 1'b0;
    bus.blank_lz = 1'b0;
    bus.digits_in = '0;
    test_reset();
    test_scan_1234();
    test_blank_lz();
    test_invalid();
    test_ignore_unlatched();
    test_back_to_back();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
